// File: rtl/move_arbiter_pkg.sv
// Shared types and codes for the tic-tac-toe move arbiter.
package ttt_pkg;
    localparam int NUM_CELLS = 9;

    typedef enum logic [2:0] {IDLE, P_TURN, C_TURN, WRITE, EVAL, DONE} state_t;

    localparam logic [1:0] EMPTY  = 2'b00;
    localparam logic [1:0] PLAYER = 2'b01;
    localparam logic [1:0] COMP   = 2'b10;

    localparam logic [1:0] TURN_NONE = 2'b00;
    localparam logic [1:0] TURN_P    = 2'b01;
    localparam logic [1:0] TURN_C    = 2'b10;

    // Out-of-range positions map to an all-zero strobe.
    function automatic logic [NUM_CELLS-1:0] cell_onehot(input logic [3:0] pos);
        cell_onehot = '0;
        for (int k = 0; k < NUM_CELLS; k++)
            if (pos == 4'(k)) cell_onehot[k] = 1'b1;
    endfunction
endpackage

// File: rtl/move_arbiter_if.sv
// Game-side bus of the move arbiter: move handshakes, board status, write strobe, status.
interface move_arbiter_if;
    import ttt_pkg::*;

    logic                   start;
    logic                   first_comp;
    logic                   p_valid;
    logic                   p_ready;
    logic [3:0]             p_pos;
    logic                   c_valid;
    logic                   c_ready;
    logic [3:0]             c_pos;
    logic [2*NUM_CELLS-1:0] board;
    logic                   win;
    logic                   filled;
    logic [NUM_CELLS-1:0]   wr_en;
    logic [1:0]             wr_who;
    logic [1:0]             turn;
    logic [3:0]             move_cnt;
    logic                   illegal;
    logic                   timeout;
    logic                   game_over;

    modport master (
        output start, first_comp, p_valid, p_pos, c_valid, c_pos, board, win, filled,
        input  p_ready, c_ready, wr_en, wr_who, turn, move_cnt, illegal, timeout, game_over
    );

    modport slave (
        input  start, first_comp, p_valid, p_pos, c_valid, c_pos, board, win, filled,
        output p_ready, c_ready, wr_en, wr_who, turn, move_cnt, illegal, timeout, game_over
    );
endinterface

// File: rtl/move_arbiter_cell_legal.sv
// Combinational legality check: position in range and target cell empty.
module cell_legal
    import ttt_pkg::*;
(
    input  logic [3:0]             pos,
    input  logic [2*NUM_CELLS-1:0] board,
    output logic                   legal
);
    always_comb begin
        legal = 1'b0;
        for (int k = 0; k < NUM_CELLS; k++)
            if (pos == 4'(k)) legal = (board[2*k +: 2] == EMPTY);
    end
endmodule

// File: rtl/move_arbiter.sv
// Turn arbiter between player and computer; writes legal moves and tracks game state.
// Optional per-turn timeout is enabled by defining TURN_TIMEOUT_EN.
module move_arbiter
    import ttt_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
)(
    input  logic          clock,
    input  logic          reset,
    move_arbiter_if.slave bus
);
    state_t     state, state_n;
    logic       mover_c;
    logic       side_c;
    logic [3:0] sel_pos;
    logic       hs;
    logic       pos_ok;
    logic       take, bad, tmo;
    logic       expire;
    logic       restart;

    // Readies are registered and only high in their own turn, so hs is already side-qualified.
    assign side_c  = (state == C_TURN);
    assign sel_pos = side_c ? bus.c_pos : bus.p_pos;
    assign hs      = side_c ? (bus.c_valid & bus.c_ready) : (bus.p_valid & bus.p_ready);
    assign restart = ((state == IDLE) || (state == DONE)) && bus.start;

    cell_legal u_legal (
        .pos   (sel_pos),
        .board (bus.board),
        .legal (pos_ok)
    );

`ifdef TURN_TIMEOUT_EN
    logic [15:0] timer;
    assign expire = ((state == P_TURN) || (state == C_TURN)) && (timer == 16'(TIMEOUT_CYC - 1));
`else
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        take    = 1'b0;
        bad     = 1'b0;
        tmo     = 1'b0;
        case (state)
            IDLE, DONE: if (bus.start) state_n = bus.first_comp ? C_TURN : P_TURN;
            P_TURN, C_TURN: begin
                // A handshake on the expiry edge takes precedence over the timeout.
                if (hs) begin
                    if (pos_ok) begin
                        take    = 1'b1;
                        state_n = WRITE;
                    end else begin
                        bad = 1'b1;
                    end
                end else if (expire) begin
                    tmo     = 1'b1;
                    state_n = side_c ? P_TURN : C_TURN;
                end
            end
            WRITE:   state_n = EVAL;
            EVAL:    state_n = (bus.win || bus.filled) ? DONE : (mover_c ? P_TURN : C_TURN);
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mover_c       <= 1'b0;
            bus.p_ready   <= 1'b0;
            bus.c_ready   <= 1'b0;
            bus.turn      <= TURN_NONE;
            bus.wr_en     <= '0;
            bus.wr_who    <= EMPTY;
            bus.move_cnt  <= '0;
            bus.illegal   <= 1'b0;
            bus.game_over <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            bus.timeout   <= 1'b0;
            timer         <= '0;
`endif
        end else begin
            state         <= state_n;
            bus.p_ready   <= (state_n == P_TURN);
            bus.c_ready   <= (state_n == C_TURN);
            bus.turn      <= (state_n == P_TURN) ? TURN_P :
                             (state_n == C_TURN) ? TURN_C : TURN_NONE;
            bus.game_over <= (state_n == DONE);
            bus.illegal   <= bad;
            bus.wr_en     <= take ? cell_onehot(sel_pos) : '0;
            bus.wr_who    <= take ? (side_c ? COMP : PLAYER) : EMPTY;
            if (take) mover_c <= side_c;
            if (restart)
                bus.move_cnt <= '0;
            else if (take && (bus.move_cnt < 4'd9))
                bus.move_cnt <= bus.move_cnt + 4'd1;
`ifdef TURN_TIMEOUT_EN
            bus.timeout <= tmo;
            // Any state change (including a timeout hand-over) restarts the turn timer.
            if ((state_n == state) && ((state == P_TURN) || (state == C_TURN)))
                timer <= timer + 16'd1;
            else
                timer <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_move_arbiter.sv
// Scoreboard bench for move_arbiter: expected write/illegal/timeout events are queued
// at stimulus time and popped by a negedge monitor whenever the DUT emits one.
module tb_move_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;

    move_arbiter_if bus ();

    move_arbiter #(.TIMEOUT_CYC(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         kind;   // 0 write, 1 illegal, 2 timeout
        logic [8:0] wr_en;
        logic [1:0] who;
        logic [3:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_cnt = 0;

    function automatic logic [8:0] tb_onehot(input logic [3:0] pos);
        logic [8:0] v;
        v = 9'd1;
        return v << pos;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_ev(input int kind, input logic [8:0] wr, input logic [1:0] who);
        ev_t e;
        e.kind  = kind;
        e.wr_en = wr;
        e.who   = who;
        e.cnt   = 4'(exp_cnt);
        exp_q.push_back(e);
    endtask

    // Legal move: handshake, write cycle, eval cycle, then next state.
    task automatic move(input bit side_c, input logic [3:0] pos, input bit upd,
                        input bit w, input bit f);
        exp_cnt = (exp_cnt < 9) ? exp_cnt + 1 : 9;
        push_ev(0, tb_onehot(pos), side_c ? 2'b10 : 2'b01);
        if (side_c) begin bus.c_valid = 1'b1; bus.c_pos = pos; end
        else        begin bus.p_valid = 1'b1; bus.p_pos = pos; end
        tick();
        bus.p_valid = 1'b0;
        bus.c_valid = 1'b0;
        if (upd) bus.board[2*pos +: 2] = side_c ? 2'b10 : 2'b01;
        bus.win    = w;
        bus.filled = f;
        tick();
        tick();
        bus.win    = 1'b0;
        bus.filled = 1'b0;
    endtask

    always @(negedge clock) begin
        ev_t o, e;
        if (!reset && (bus.wr_en != 9'd0 || bus.illegal || bus.timeout)) begin
            o.kind  = bus.timeout ? 2 : (bus.illegal ? 1 : 0);
            o.wr_en = bus.wr_en;
            o.who   = bus.wr_who;
            o.cnt   = bus.move_cnt;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got kind %0d wr_en %h who %0d cnt %0d expected none",
                         o.kind, o.wr_en, o.who, o.cnt);
            end else begin
                e = exp_q.pop_front();
                if (o.kind != e.kind || o.wr_en != e.wr_en || o.who != e.who || o.cnt != e.cnt) begin
                    errors++;
                    $display("FAIL event: got kind %0d wr_en %h who %0d cnt %0d expected kind %0d wr_en %h who %0d cnt %0d",
                             o.kind, o.wr_en, o.who, o.cnt, e.kind, e.wr_en, e.who, e.cnt);
                end
            end
        end
    end

    initial begin
        bus.start = 0; bus.first_comp = 0; bus.p_valid = 0; bus.p_pos = 0;
        bus.c_valid = 0; bus.c_pos = 0; bus.board = '0; bus.win = 0; bus.filled = 0;
        tick();
        tick();
        chk("rst_p_ready", bus.p_ready, 0);
        chk("rst_c_ready", bus.c_ready, 0);
        chk("rst_turn", bus.turn, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_who", bus.wr_who, 0);
        chk("rst_move_cnt", bus.move_cnt, 0);
        chk("rst_flags", {bus.illegal, bus.timeout, bus.game_over}, 0);
        reset = 1'b0;
        tick();
        chk("idle_wait", bus.p_ready, 0);

        // Player-first game
        bus.first_comp = 0; bus.start = 1; tick(); bus.start = 0; exp_cnt = 0;
        chk("p_turn_ready", {bus.p_ready, bus.c_ready}, 2'b10);
        chk("p_turn_code", bus.turn, 2'b01);
        move(0, 4, 1, 0, 0);
        chk("after_p_ready", {bus.p_ready, bus.c_ready}, 2'b01);
        chk("after_p_turn", bus.turn, 2'b10);
        chk("after_p_cnt", bus.move_cnt, 1);
        move(1, 0, 1, 0, 0);
        chk("after_c_ready", bus.p_ready, 1);

        // Occupied cell
        push_ev(1, 9'd0, 2'b00);
        bus.p_valid = 1; bus.p_pos = 4; tick(); bus.p_valid = 0;
        chk("occ_ready_held", bus.p_ready, 1);
        chk("occ_no_write", bus.wr_en, 0);
        tick();
        chk("occ_pulse_end", bus.illegal, 0);
        chk("occ_cnt", bus.move_cnt, 2);

        // Out of range with stray computer valid
        push_ev(1, 9'd0, 2'b00);
        bus.p_valid = 1; bus.p_pos = 11; bus.c_valid = 1; bus.c_pos = 1;
        tick(); bus.p_valid = 0;
        chk("oor_c_ready", bus.c_ready, 0);
        chk("oor_turn", bus.turn, 2'b01);
        repeat (3) tick();
        bus.c_valid = 0;
        chk("stray_c_ignored", {bus.p_ready, bus.move_cnt}, {1'b1, 4'd2});

        move(0, 1, 1, 0, 0);
        move(1, 2, 1, 0, 0);
        move(0, 8, 1, 1, 0);
        chk("win_game_over", bus.game_over, 1);
        chk("win_turn", bus.turn, 0);
        chk("win_cnt", bus.move_cnt, 5);
        chk("win_readies", {bus.p_ready, bus.c_ready}, 0);
        bus.p_valid = 1; bus.p_pos = 3;
        repeat (3) tick();
        bus.p_valid = 0;
        chk("done_hold", {bus.game_over, bus.wr_en}, {1'b1, 9'd0});

        // Restart, computer first; mid-game start ignored
        bus.board = '0; bus.first_comp = 1; bus.start = 1; tick(); bus.start = 0; exp_cnt = 0;
        chk("restart_cnt", bus.move_cnt, 0);
        chk("restart_turn", {bus.c_ready, bus.turn}, {1'b1, 2'b10});
        chk("restart_go", bus.game_over, 0);
        bus.first_comp = 0; bus.start = 1; tick(); bus.start = 0;
        chk("start_ignored", {bus.c_ready, bus.turn}, {1'b1, 2'b10});
        move(1, 4, 1, 1, 1);
        chk("win_filled_done", {bus.game_over, bus.move_cnt}, {1'b1, 4'd1});

        // Saturation: board kept empty so the same cell stays legal
        bus.board = '0; bus.start = 1; tick(); bus.start = 0; exp_cnt = 0;
        for (int i = 0; i < 10; i++) move(bit'(i % 2), 4'd0, 0, 0, 0);
        chk("sat_cnt", bus.move_cnt, 9);

        // Reset during the write cycle
        bus.p_valid = 1; bus.p_pos = 3; tick(); bus.p_valid = 0;
        chk("pre_rst_wr_en", bus.wr_en, 9'h008);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", bus.wr_en, 0);
        chk("mid_rst_who", bus.wr_who, 0);
        chk("mid_rst_state", {bus.p_ready, bus.c_ready, bus.turn, bus.move_cnt}, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_idle", {bus.p_ready, bus.c_ready}, 0);

        bus.start = 1; bus.first_comp = 0; tick(); bus.start = 0; exp_cnt = 0;
`ifdef TURN_TIMEOUT_EN
        push_ev(2, 9'd0, 2'b00);
        repeat (3) tick();
        chk("tmo_not_yet", {bus.timeout, bus.turn}, {1'b0, 2'b01});
        tick();
        chk("tmo_pulse", bus.timeout, 1);
        chk("tmo_turn", {bus.c_ready, bus.turn}, {1'b1, 2'b10});
        chk("tmo_cnt", bus.move_cnt, 0);
        repeat (3) tick();
        move(1, 5, 1, 0, 0);
        chk("hs_beats_tmo", {bus.p_ready, bus.move_cnt}, {1'b1, 4'd1});
`else
        repeat (20) tick();
        chk("no_tmo_wait", {bus.p_ready, bus.turn, bus.timeout}, {1'b1, 2'b01, 1'b0});
`endif
        tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
